// File: rtl/ymat_row_fetch.sv
// Y-matrix row fetch: turns a (row, col, len) element request into a burst of
// SRAM word addresses with a start lane and a last-word marker.
module ymat_row_fetch #(
  parameter int ROW_W      = 8,
  parameter int IDX_W      = 16,
  parameter int LEN_W      = 8,
  parameter int ADDR_W     = 11,
  parameter int ELEM_SHIFT = 4,
  parameter int ROW_WORDS  = 64,
  parameter int DEPTH      = 2048
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  yRF_req_valid,
  output logic                  yRF_req_ready,
  input  logic [ROW_W-1:0]      yRF_req_row,
  input  logic [IDX_W-1:0]      yRF_req_col,
  input  logic [LEN_W-1:0]      yRF_req_len,
  output logic                  yRF_addr_valid,
  input  logic                  yRF_addr_ready,
  output logic [ADDR_W-1:0]     yRF_addr,
  output logic [ELEM_SHIFT-1:0] yRF_addr_lane,
  output logic                  yRF_addr_last,
  output logic                  yRF_done,
  output logic                  yRF_err,
  output logic [1:0]            yRF_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid side holds its payload unchanged until that edge.

  localparam int BASE_W = ROW_W + $clog2(ROW_WORDS + 1);
  localparam int A_W    = (BASE_W > IDX_W + 1) ? BASE_W : IDX_W + 1;
  localparam int C_W    = ((A_W > ADDR_W) ? A_W : ADDR_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                state_q;
  logic                  ready_q, valid_q, last_q, done_q, err_q;
  logic [ROW_W-1:0]      row_q;
  logic [IDX_W-1:0]      col_q;
  logic [LEN_W-1:0]      len_q;
  logic [ADDR_W-1:0]     cur_q, end_q;
  logic [ELEM_SHIFT-1:0] lane_q;

  logic [C_W-1:0]    sw_c, ew_c, base_c;
  logic              reject_c;
  logic [ADDR_W-1:0] cur_d, end_d, cur_inc;

  // Wide enough that neither the end index nor base + ew can wrap.
  always_comb begin
    sw_c     = C_W'(col_q >> ELEM_SHIFT);
    ew_c     = C_W'(({1'b0, col_q} + (IDX_W+1)'(len_q) - (IDX_W+1)'(1)) >> ELEM_SHIFT);
    base_c   = C_W'(row_q) * C_W'(ROW_WORDS);
    reject_c = (len_q == '0) || (ew_c >= C_W'(ROW_WORDS)) ||
               ((base_c + ew_c) >= C_W'(DEPTH));
    cur_d    = ADDR_W'(base_c + sw_c);
    end_d    = ADDR_W'(base_c + ew_c);
    cur_inc  = cur_q + ADDR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      len_q   <= '0;
      cur_q   <= '0;
      end_q   <= '0;
      lane_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (yRF_req_valid) begin
            row_q   <= yRF_req_row;
            col_q   <= yRF_req_col;
            len_q   <= yRF_req_len;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (reject_c) begin
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cur_q   <= cur_d;
            end_q   <= end_d;
            lane_q  <= col_q[ELEM_SHIFT-1:0];
            last_q  <= (cur_d == end_d);
            valid_q <= 1'b1;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (yRF_addr_ready) begin
            lane_q <= '0;
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              cur_q  <= cur_inc;
              last_q <= (cur_inc == end_q);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign yRF_req_ready  = ready_q;
  assign yRF_addr_valid = valid_q;
  assign yRF_addr       = cur_q;
  assign yRF_addr_lane  = lane_q;
  assign yRF_addr_last  = last_q;
  assign yRF_done       = done_q;
  assign yRF_err        = err_q;
  assign yRF_dbg_state  = state_q;

endmodule

// File: tb/tb_ymat_row_fetch.sv
// Directed bench for ymat_row_fetch: bursts, backpressure, rejects, reset
// mid-burst and back-to-back requests against hand-computed addresses.
module tb_ymat_row_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_row = '0;
  logic [15:0] req_col = '0;
  logic [7:0]  req_len = '0;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [10:0] addr;
  logic [3:0]  addr_lane;
  logic        addr_last;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  ymat_row_fetch dut (
    .clock(clk), .reset(rst_n),
    .yRF_req_valid(req_valid), .yRF_req_ready(req_ready),
    .yRF_req_row(req_row), .yRF_req_col(req_col), .yRF_req_len(req_len),
    .yRF_addr_valid(addr_valid), .yRF_addr_ready(addr_ready),
    .yRF_addr(addr), .yRF_addr_lane(addr_lane), .yRF_addr_last(addr_last),
    .yRF_done(done), .yRF_err(err), .yRF_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input int a, input int lane, input bit last);
    return {a[10:0], lane[3:0], last};
  endfunction

  // driver: accept cycle, then CALC cycle with a junk request that must be ignored
  task automatic do_req(input int row, input int col, input int len);
    req_row   = row[7:0];
    req_col   = col[15:0];
    req_len   = len[7:0];
    req_valid = 1'b1;
    check("req_ready", req_ready, 1);
    step();
    req_row = 8'd7;
    req_col = 16'd99;
    req_len = 8'd3;
    check("busy_ready", req_ready, 0);
    check("calc_valid", addr_valid, 0);
    step();
    req_valid = 1'b0;
  endtask

  // collector: walks exp_q against handshakes, checks stalls hold the word
  task automatic run_burst(input logic [15:0] rdy_pat, input int pat_len);
    int cyc = 0;
    int idx = 0;
    logic held = 1'b0;
    logic [16:0] held_v = '0;
    logic [16:0] cur;
    logic r;
    check("first_valid", addr_valid, 1);
    while (exp_q.size() > 0 && cyc < 40) begin
      cur = {addr_valid, addr, addr_lane, addr_last};
      if (held) check("stall_hold", cur, held_v);
      r = (idx < pat_len) ? rdy_pat[idx] : 1'b1;
      idx++;
      addr_ready = r;
      if (addr_valid && r) begin
        check("word", cur[15:0], exp_q.pop_front());
        held = 1'b0;
      end else if (addr_valid) begin
        held   = 1'b1;
        held_v = cur;
      end
      step();
      cyc++;
    end
    addr_ready = 1'b0;
    check("words_left", exp_q.size(), 0);
    check("done_pulse", done, 1);
    check("done_ready", req_ready, 1);
    check("done_valid", addr_valid, 0);
  endtask

  task automatic reject_case(input string tag, input int row, input int col, input int len);
    do_req(row, col, len);
    check({tag, "_err"}, err, 1);
    check({tag, "_valid"}, addr_valid, 0);
    check({tag, "_ready"}, req_ready, 1);
    step();
    check({tag, "_err_once"}, err, 0);
    check({tag, "_no_done"}, done, 0);
  endtask

  initial begin
    step();
    step();
    check("rst_valid", addr_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", addr, 0);
    rst_n = 1'b1;
    step();
    check("rst_ready", req_ready, 1);

    // legacy single address
    exp_q.push_back(mk(12'h012, 3, 1));
    do_req(0, 16'h0123, 1);
    run_burst(16'h0001, 1);

    // back-to-back request in the done cycle: row 5 col 16 len 16 -> 321
    exp_q.push_back(mk(321, 0, 1));
    do_req(5, 16, 16);
    run_burst(16'h0001, 1);
    step();

    // multi-word burst with ready held high
    exp_q.push_back(mk(129, 14, 0));
    exp_q.push_back(mk(130, 0, 0));
    exp_q.push_back(mk(131, 0, 0));
    exp_q.push_back(mk(132, 0, 1));
    do_req(2, 30, 40);
    run_burst(16'h007F, 7);
    step();

    // same burst under backpressure 1,0,0,1,0,1,1
    exp_q.push_back(mk(129, 14, 0));
    exp_q.push_back(mk(130, 0, 0));
    exp_q.push_back(mk(131, 0, 0));
    exp_q.push_back(mk(132, 0, 1));
    do_req(2, 30, 40);
    run_burst(16'b1101001, 7);
    step();

    // top-of-SRAM boundary: row 31 col 1008 len 16 -> 2047
    exp_q.push_back(mk(2047, 0, 1));
    do_req(31, 1008, 16);
    run_burst(16'h0001, 1);
    step();

    reject_case("len0", 3, 5, 0);
    reject_case("ew64", 31, 1020, 8);
    reject_case("row40", 40, 0, 1);

    // reset during the second word of row 1 col 0 len 64 (64..67)
    do_req(1, 0, 64);
    check("mr_w0", addr, 64);
    addr_ready = 1'b1;
    step();
    addr_ready = 1'b0;
    check("mr_w1", addr, 65);
    rst_n = 1'b0;
    step();
    check("mr_valid", addr_valid, 0);
    check("mr_done", done, 0);
    check("mr_err", err, 0);
    check("mr_last", addr_last, 0);
    check("mr_addr", addr, 0);
    rst_n = 1'b1;
    step();
    check("mr_ready", req_ready, 1);
    check("mr_no_done", done, 0);

    // fresh request after reset: row 3 col 5 len 20 -> 192 (lane 5), 193
    exp_q.push_back(mk(192, 5, 0));
    exp_q.push_back(mk(193, 0, 1));
    do_req(3, 5, 20);
    run_burst(16'h0003, 2);
    step();
    check("end_idle", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ymat_row_fetch.md
# ymat_row_fetch

Parametrised successor to the single-shot Y-matrix row address divider. It accepts a request for a contiguous run of elements in one row of the Y-matrix SRAM and emits the sequence of SRAM word addresses covering that run, one per cycle, under a valid/ready handshake. It range-checks every request against SRAM depth and reports a start lane and a last-word marker so the downstream unpacker can select elements. It sits between the matrix-solve sequencer and the Y-matrix SRAM read port.

## Interface
Parameters:
- ROW_W, 8: width of the matrix row index.
- IDX_W, 16: width of the element column index.
- LEN_W, 8: width of the element count.
- ADDR_W, 11: SRAM word address width.
- ELEM_SHIFT, 4: log2 of elements per SRAM word; 4 gives the legacy divide-by-16.
- ROW_WORDS, 64: SRAM words reserved per matrix row.
- DEPTH, 2048: number of valid SRAM words; must be ≤ 2^ADDR_W.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- yRF_req_valid  in  1  request present.
- yRF_req_ready  out  1  block can accept a request.
- yRF_req_row  in  ROW_W  matrix row.
- yRF_req_col  in  IDX_W  first element index within the row.
- yRF_req_len  in  LEN_W  element count.
- yRF_addr_valid  out  1  yRF_addr is valid.
- yRF_addr_ready  in  1  SRAM side accepts the address.
- yRF_addr  out  ADDR_W  SRAM word address.
- yRF_addr_lane  out  ELEM_SHIFT  element offset inside the word; nonzero only on the first word.
- yRF_addr_last  out  1  final word of the burst.
- yRF_done  out  1  one-cycle pulse after the final address handshake.
- yRF_err  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, CALC, BURST.
- IDLE:
  - yRF_req_ready = 1.
  - On yRF_req_valid, capture row, col and len, then go to CALC.
- CALC (1 cycle):
  - sw = col >> ELEM_SHIFT.
  - ew = (col + len − 1) >> ELEM_SHIFT, computed at IDX_W+1 bits with no wrap.
  - base = row × ROW_WORDS, at full product width.
  - Reject if any of these hold: len == 0; ew ≥ ROW_WORDS; base + ew ≥ DEPTH.
  - On reject: yRF_err pulses, then return to IDLE. No addresses are issued.
  - Otherwise: cur = base + sw, end = base + ew, lane = col[ELEM_SHIFT−1:0]; go to BURST.
- BURST:
  - yRF_addr_valid = 1 and yRF_addr = cur[ADDR_W−1:0].
  - yRF_addr_last = (cur == end).
  - yRF_addr_lane = lane on the first word of the burst, 0 on every later word.
  - On handshake (valid & ready) with last = 0: cur increments and lane clears.
  - On handshake with last = 1: go to IDLE and pulse yRF_done in the next cycle.
  - Without yRF_addr_ready, all outputs hold stable; no address is dropped or repeated.
- Requests are never queued. While the block is busy, yRF_req_ready = 0 and yRF_req_valid is ignored.
- Reset (reset == 0) at any cycle, including mid-burst:
  - State returns to IDLE and the burst in progress is abandoned.
  - All outputs are 0 in the following cycle, except yRF_req_ready, which is 1 once reset is released.
  - No done or err pulse is produced for the abandoned burst.
- Legacy equivalence: with ROW_WORDS = 0-row use (row = 0), len = 1 and ELEM_SHIFT = 4, the block emits the single address col >> 4.

## Timing
- Request acceptance to first yRF_addr_valid: 2 cycles (acceptance cycle, then CALC).
- Throughput: 1 address per cycle while yRF_addr_ready is held high.
- An N-word burst with ready held high occupies N+2 cycles from acceptance to the IDLE state.
- yRF_done asserts the cycle after the last handshake, coincident with yRF_req_ready = 1. A new request may be accepted in that same cycle.
- yRF_err asserts in the cycle after CALC, coincident with the return to IDLE.
- All outputs are registered; there is no combinational path from yRF_addr_ready to any output.

## Test plan
- Legacy single address: row 0, col 0x0123, len 1 → one address 0x012, lane 3, last = 1, then done. Output appears 2 cycles after acceptance.
- Multi-word burst: row 2, col 30, len 40 → sw = 1, ew = 4, addresses 129, 130, 131, 132. Lane is 14 on the first word, 0 afterwards; last = 1 only on 132.
- Backpressure: same burst as above with yRF_addr_ready toggled 1,0,0,1,0,1,1 → each address is held stable through stalls, the sequence is unchanged, and done follows the 4th handshake.
- Rejects, each giving one yRF_err pulse, no addr_valid, and ready again 2 cycles after acceptance:
  - len 0.
  - row 31, col 1020, len 8 (ew = 64 ≥ ROW_WORDS).
  - row 40 (base = 2560 ≥ DEPTH).
- Reset mid-burst: drop reset during the 2nd word of a 4-word burst → the next cycle shows addr_valid = 0, done = 0, err = 0. A fresh request after reset release produces a correct sequence.
- Back-to-back requests: present a new request in the done cycle → it is accepted immediately and its first address appears 2 cycles later.
